// File: rtl/sseg_frame_capture.sv
// Receive side of the multiplexed seven-segment digit bus: decodes the scanned
// digit enable, rebuilds six digit patterns and publishes complete frames.
module sseg_frame_capture #(
    parameter int unsigned        SEG_W = 8,
    parameter logic [SEG_W-1:0]   BLANK = '1,
    parameter int unsigned        ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [5:0]           disp_en,
    input  logic [SEG_W-1:0]     sseg,
    input  logic                 clr_err,
    output logic [6*SEG_W-1:0]   digits,
    output logic                 frame_vld,
    output logic                 seq_err,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 sync
);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         exp_q, exp_d;
    logic [SEG_W-1:0]   work_q [6];
    logic [SEG_W-1:0]   work_d [6];
    logic [6*SEG_W-1:0] digits_q, digits_d;
    logic               vld_q, vld_d;
    logic               seq_q, seq_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic [5:0]         low;
    logic [2:0]         n_low;
    logic [2:0]         idx;
    logic               valid;
    logic               err_ev;
    logic [ERR_W-1:0]   err_base;

    // Active-low one-hot decode: exactly one low bit makes a valid sample.
    always_comb begin
        low   = ~disp_en;
        n_low = '0;
        idx   = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (low[i]) begin
                n_low = n_low + 3'd1;
                idx   = 3'(i);
            end
        end
        valid = (n_low == 3'd1);
    end

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        work_d   = work_q;
        digits_d = digits_q;
        vld_d    = 1'b0;
        err_ev   = 1'b0;
        if (sample_en) begin
            case (state_q)
                HUNT: begin
                    if (valid && idx == 3'd0) begin
                        work_d[0] = sseg;
                        exp_d     = 3'd1;
                        state_d   = COLLECT;
                    end else if (!valid) begin
                        err_ev = 1'b1;
                    end
                end
                COLLECT: begin
                    if (valid && idx == exp_q) begin
                        for (int unsigned i = 0; i < 6; i++)
                            if (3'(i) == idx) work_d[i] = sseg;
                        if (idx == 3'd5) begin
                            for (int unsigned i = 0; i < 5; i++)
                                digits_d[i*SEG_W +: SEG_W] = work_q[i];
                            digits_d[5*SEG_W +: SEG_W] = sseg;
                            vld_d = 1'b1;
                            exp_d = 3'd0;
                        end else begin
                            exp_d = exp_q + 3'd1;
                        end
                    end else begin
                        err_ev = 1'b1;
                        // An out-of-order digit 0 restarts the frame rather than losing sync.
                        if (valid && idx == 3'd0) begin
                            work_d[0] = sseg;
                            exp_d     = 3'd1;
                        end else begin
                            exp_d   = 3'd0;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Clear applies first so a same-cycle error event is still counted.
    always_comb begin
        err_base = clr_err ? '0 : err_q;
        seq_d    = clr_err ? 1'b0 : seq_q;
        err_d    = err_base;
        if (err_ev) begin
            seq_d = 1'b1;
            if (err_base != '1) err_d = err_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            exp_q    <= '0;
            digits_q <= {6{BLANK}};
            vld_q    <= 1'b0;
            seq_q    <= 1'b0;
            err_q    <= '0;
            for (int unsigned i = 0; i < 6; i++) work_q[i] <= BLANK;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            digits_q <= digits_d;
            vld_q    <= vld_d;
            seq_q    <= seq_d;
            err_q    <= err_d;
            work_q   <= work_d;
        end
    end

    assign digits    = digits_q;
    assign frame_vld = vld_q;
    assign seq_err   = seq_q;
    assign err_cnt   = err_q;
    assign sync      = (state_q == COLLECT);

endmodule
